// File: rtl/ledg_setclr_arbiter_pkg.sv
// Shared definitions for the green-LED set/clear arbiter.
//   ADDR_SET / ADDR_CLR : PIO word offsets of the bit-set / bit-clear registers
//   op_e                : requester operation encoding (clear = 0, set = 1)
//   state_e             : arbiter FSM states
package ledg_pkg;

  localparam logic [2:0] ADDR_SET = 3'd4;
  localparam logic [2:0] ADDR_CLR = 3'd5;

  typedef enum logic {
    OP_CLR = 1'b0,
    OP_SET = 1'b1
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/ledg_setclr_arbiter_if.sv
// Avalon-MM write-only master bus between the arbiter and the LED PIO.
//   avm_address     : word address (set or clear register)
//   avm_chipselect  : transfer select
//   avm_write_n     : write strobe, active low
//   avm_writedata   : bit mask, zero-extended to 32 bits
//   avm_waitrequest : fabric stall back to the master
interface ledg_setclr_arbiter_if;

  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_waitrequest
  );

endinterface

// File: rtl/ledg_setclr_arbiter_rr.sv
// Combinational round-robin picker.
//   req_valid : per-requester valid
//   rr_ptr    : index where the search starts
//   grant     : one-hot pick (all zero when nothing is valid)
//   grant_idx : encoded pick
//   grant_any : some requester was picked
module ledg_setclr_arbiter_rr #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [2:0]         rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_idx,
  output logic               grant_any
);

  logic [7:0] valid_pad;
  logic [3:0] idx;

  // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; the first valid lane wins.
  // The vector is padded to 8 lanes so a 3-bit index always fits.
  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_REQ-1:0]   = req_valid;
    grant_idx                = '0;
    grant_any                = 1'b0;
    idx                      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(NUM_REQ)) begin
        idx = idx - 4'(NUM_REQ);
      end
      if (!grant_any && valid_pad[idx[2:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[2:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = grant_any && (grant_idx == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/ledg_setclr_arbiter.sv
// Arbitrates set/clear requests for the shared green-LED PIO and turns each
// granted request into a single Avalon-MM write to the bit-set or bit-clear
// register, so requesters never overwrite each other's LED bits.
//   clk, reset_n : clock, synchronous active-low reset
//   req_valid    : per-requester request valid
//   req_op       : per-requester op (1 = set bits, 0 = clear bits)
//   req_mask     : per-requester mask, lane i at [i*DATA_W +: DATA_W]
//   req_ready    : one-hot accept strobe (combinational, only in IDLE)
//   avm          : Avalon-MM master port (registered outputs)
//   busy         : high while a write is on the bus
//   grant_id     : index of the requester currently or last served
module ledg_setclr_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter int         DATA_W   = 8,
  parameter logic [2:0] ADDR_SET = ledg_pkg::ADDR_SET,
  parameter logic [2:0] ADDR_CLR = ledg_pkg::ADDR_CLR
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_mask,
  output logic [NUM_REQ-1:0]        req_ready,
  ledg_setclr_arbiter_if.master     avm,
  output logic                      busy,
  output logic [2:0]                grant_id
);

  import ledg_pkg::*;

  state_e            state_q;
  logic [2:0]        rr_ptr_q;
  logic [2:0]        grant_id_q;
  logic              cs_q;
  logic              write_n_q;
  logic [2:0]        addr_q;
  logic [31:0]       wdata_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [2:0]         pick_idx;
  logic               pick_any;
  logic               take;
  logic [2:0]         rr_ptr_d;
  logic [2:0]         addr_d;
  logic [DATA_W-1:0]  mask_d;
  logic [31:0]        wdata_d;

  // Lanes padded to 8 so the 3-bit pick index can select directly.
  logic [DATA_W-1:0] mask_lane [8];
  logic [7:0]        op_pad;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < NUM_REQ) begin : g_real
        assign mask_lane[gi] = req_mask[gi*DATA_W +: DATA_W];
        assign op_pad[gi]    = req_op[gi];
      end else begin : g_pad
        assign mask_lane[gi] = '0;
        assign op_pad[gi]    = 1'b0;
      end
    end
  endgenerate

  ledg_setclr_arbiter_rr #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  // Ready is gated by reset so no request is consumed on a reset edge.
  assign req_ready = (state_q == ST_IDLE && reset_n) ? pick_onehot : '0;
  assign take      = pick_any && (state_q == ST_IDLE);

  assign mask_d   = mask_lane[pick_idx];
  assign addr_d   = (op_pad[pick_idx] == OP_SET) ? ADDR_SET : ADDR_CLR;
  assign rr_ptr_d = (pick_idx == 3'(NUM_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;

  always_comb begin
    wdata_d               = '0;
    wdata_d[DATA_W-1:0]   = mask_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      cs_q       <= 1'b0;
      write_n_q  <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            grant_id_q <= pick_idx;
            rr_ptr_q   <= rr_ptr_d;
            // A zero mask is consumed without a bus cycle.
            if (|mask_d) begin
              state_q   <= ST_WRITE;
              cs_q      <= 1'b1;
              write_n_q <= 1'b0;
              addr_q    <= addr_d;
              wdata_q   <= wdata_d;
            end
          end
        end
        ST_WRITE: begin
          // Address and data stay put through the stall; only the strobes drop.
          if (!avm.avm_waitrequest) begin
            state_q   <= ST_IDLE;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write_n    = write_n_q;
  assign avm.avm_writedata  = wdata_q;
  assign busy               = (state_q == ST_WRITE);
  assign grant_id           = grant_id_q;

endmodule

// File: tb/tb_ledg_setclr_arbiter.sv
module tb_ledg_setclr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_op = '0;
  logic [31:0] req_mask = '0;
  logic [3:0]  req_ready;
  logic        busy;
  logic [2:0]  grant_id;

  ledg_setclr_arbiter_if avm_bus ();

  ledg_setclr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_mask  (req_mask),
    .req_ready (req_ready),
    .avm       (avm_bus),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] lane;
    logic       op;
    logic [7:0] mask;
  } item_t;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  item_t pend_q[$];
  int    exp_grant_q[$];
  wr_t   exp_wr_q[$];
  int    rise_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cs_cycles = 0;
  int busy_cycles = 0;
  logic [3:0] acc_snap = '0;
  logic       cs_prev = 1'b0;
  logic       gid_pending = 1'b0;
  logic [2:0] gid_exp = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic issue(input int lane, input logic op, input logic [7:0] mask);
    item_t it;
    it.lane = 2'(lane);
    it.op   = op;
    it.mask = mask;
    pend_q.push_back(it);
    $display("issue lane=%0d op=%0d mask=%h", lane, op, mask);
  endtask

  task automatic expect_grant(input int lane);
    exp_grant_q.push_back(lane);
  endtask

  task automatic expect_write(input logic [2:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_wr_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (pend_q.size() != 0 || req_valid != 4'h0 || exp_grant_q.size() != 0 ||
           exp_wr_q.size() != 0 || busy !== 1'b0) begin
      step();
      n++;
      if (n > 300) begin
        check({name, "_drain_timeout"}, 32'(n), 32'd300);
        pend_q.delete();
        exp_grant_q.delete();
        exp_wr_q.delete();
        break;
      end
    end
  endtask

  // Requester lanes: drop valid after an accept, then load the next queued item.
  always @(negedge clk) acc_snap = req_valid & req_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_snap[i]) req_valid[i] = 1'b0;
      if (!req_valid[i]) begin
        for (int k = 0; k < pend_q.size(); k++) begin
          if (int'(pend_q[k].lane) == i) begin
            req_valid[i]           = 1'b1;
            req_op[i]              = pend_q[k].op;
            req_mask[i*DATA_W +: DATA_W] = pend_q[k].mask;
            pend_q.delete(k);
            break;
          end
        end
      end
    end
  end

  // Monitor: compares against the scoreboard queues, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (gid_pending) begin
      check("grant_id", 32'(grant_id), 32'(gid_exp));
      gid_pending = 1'b0;
    end
    if (req_ready !== 4'h0) begin
      if (exp_grant_q.size() == 0) begin
        check("unexpected_ready", 32'(req_ready), 32'd0);
      end else begin
        gid_exp = 3'(exp_grant_q.pop_front());
        check("req_ready", 32'(req_ready), 32'(4'b0001 << gid_exp));
        $display("grant lane=%0d ready=%b cycle=%0d", gid_exp, req_ready, cyc);
        gid_pending = 1'b1;
      end
    end
    if (avm_bus.avm_chipselect === 1'b1) begin
      cs_cycles++;
      if (!cs_prev) rise_q.push_back(cyc);
      check("ready_during_write", 32'(req_ready), 32'd0);
      check("write_n", 32'(avm_bus.avm_write_n), 32'd0);
      if (exp_wr_q.size() == 0) begin
        check("unexpected_write", 32'(avm_bus.avm_address), 32'h7);
      end else begin
        check("avm_address", 32'(avm_bus.avm_address), 32'(exp_wr_q[0].addr));
        check("avm_writedata", avm_bus.avm_writedata, exp_wr_q[0].data);
        if (avm_bus.avm_waitrequest === 1'b0) begin
          $display("write addr=%0d data=%h cycle=%0d", avm_bus.avm_address,
                   avm_bus.avm_writedata, cyc);
          void'(exp_wr_q.pop_front());
        end
      end
    end
    if (busy === 1'b1) busy_cycles++;
    if (cyc > 2) check("busy_vs_cs", 32'(busy), 32'(avm_bus.avm_chipselect));
    cs_prev = (avm_bus.avm_chipselect === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    avm_bus.avm_waitrequest = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_cs", 32'(avm_bus.avm_chipselect), 32'd0);
    check("rst_write_n", 32'(avm_bus.avm_write_n), 32'd1);
    check("rst_address", 32'(avm_bus.avm_address), 32'd0);
    check("rst_writedata", avm_bus.avm_writedata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    reset_n = 1'b1;
    step();

    // Single set: one write cycle, busy for exactly that cycle.
    cs_cycles = 0;
    busy_cycles = 0;
    issue(0, 1'b1, 8'h0F);
    expect_grant(0);
    expect_write(3'd4, 32'h0000_000F);
    wait_drain("single");
    check("single_cs_cycles", 32'(cs_cycles), 32'd1);
    check("single_busy_cycles", 32'(busy_cycles), 32'd1);

    // Reset so the round-robin pointer starts at 0.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // All four at once: order 0,1,2,3; pointer ends at 0.
    issue(0, 1'b1, 8'h11);
    issue(1, 1'b0, 8'h22);
    issue(2, 1'b1, 8'h44);
    issue(3, 1'b0, 8'h88);
    expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3);
    expect_write(3'd4, 32'h11); expect_write(3'd5, 32'h22);
    expect_write(3'd4, 32'h44); expect_write(3'd5, 32'h88);
    wait_drain("rr_all");

    // Lane 0 alone moves the pointer to 1; then 2 and 0 together -> 2 first.
    issue(0, 1'b1, 8'h03);
    expect_grant(0);
    expect_write(3'd4, 32'h03);
    wait_drain("rr_one");
    issue(2, 1'b1, 8'h30);
    issue(0, 1'b0, 8'h01);
    expect_grant(2); expect_grant(0);
    expect_write(3'd4, 32'h30); expect_write(3'd5, 32'h01);
    wait_drain("rr_pair");

    // Stall: pointer is 1, so lane 1 first; its write is held 4 cycles.
    avm_bus.avm_waitrequest = 1'b1;
    cs_cycles = 0;
    issue(1, 1'b0, 8'hA0);
    issue(2, 1'b1, 8'h0C);
    expect_grant(1); expect_grant(2);
    expect_write(3'd5, 32'hA0); expect_write(3'd4, 32'h0C);
    for (int n = 0; n < 20; n++) begin
      step();
      if (avm_bus.avm_chipselect === 1'b1) break;
    end
    repeat (3) step();
    avm_bus.avm_waitrequest = 1'b0;
    wait_drain("stall");
    check("stall_cs_cycles", 32'(cs_cycles), 32'd5);

    // Zero mask: consumed with no bus cycle; pointer wraps to 0.
    cs_cycles = 0;
    issue(3, 1'b1, 8'h00);
    expect_grant(3);
    wait_drain("zero");
    check("zero_cs_cycles", 32'(cs_cycles), 32'd0);
    issue(0, 1'b1, 8'h02);
    issue(1, 1'b1, 8'h40);
    expect_grant(0); expect_grant(1);
    expect_write(3'd4, 32'h02); expect_write(3'd4, 32'h40);
    wait_drain("after_zero");

    // Reset mid-write: lane 2 stalled (pointer becomes 3), lanes 2 and 3 held.
    avm_bus.avm_waitrequest = 1'b1;
    issue(2, 1'b1, 8'h3C);
    expect_grant(2);
    expect_write(3'd4, 32'h3C);
    for (int n = 0; n < 20; n++) begin
      step();
      if (avm_bus.avm_chipselect === 1'b1) break;
    end
    issue(2, 1'b1, 8'h05);
    issue(3, 1'b0, 8'h50);
    repeat (2) step();
    reset_n = 1'b0;
    step();
    check("midrst_cs", 32'(avm_bus.avm_chipselect), 32'd0);
    check("midrst_write_n", 32'(avm_bus.avm_write_n), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_address", 32'(avm_bus.avm_address), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    if (exp_wr_q.size() != 0) void'(exp_wr_q.pop_front());
    avm_bus.avm_waitrequest = 1'b0;
    step();
    reset_n = 1'b1;
    // Pointer back at 0: lane 2 before lane 3.
    expect_grant(2); expect_grant(3);
    expect_write(3'd4, 32'h05); expect_write(3'd5, 32'h50);
    wait_drain("post_reset");

    // Back-to-back from lane 0: one idle bus cycle between the writes.
    rise_q.delete();
    issue(0, 1'b1, 8'h01);
    issue(0, 1'b1, 8'h02);
    expect_grant(0); expect_grant(0);
    expect_write(3'd4, 32'h01); expect_write(3'd4, 32'h02);
    wait_drain("b2b");
    check("b2b_writes", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() == 2) check("b2b_gap", 32'(rise_q[1] - rise_q[0]), 32'd2);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
